// File: rtl/axis_dma_bram_fsm.sv
// axis_dma_bram_fsm: receives a fixed-size AXI-Stream frame into an internal
// BRAM, hands the buffer to a processing core with a start/done handshake,
// then streams the buffer back out with TLAST and returns to idle.
// Optional build macro AXIS_DMA_AUTO_DONE_EN: when defined, an internal done
// fires one cycle after proc_start (OR'd with proc_done) for standalone loopback.
module axis_dma_bram_fsm #(
  parameter int DATA_WIDTH = 32,
  parameter int length     = 16
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  start_process,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  proc_start,
  input  logic                  proc_done
);

  localparam int NUM_IN = 3 * length;
  localparam int ADDR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int CNT_W  = $clog2(NUM_IN + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_IN - 1);
  localparam logic [CNT_W-1:0]  NUM_IN_C = CNT_W'(NUM_IN);

  typedef enum logic [1:0] {S_IDLE, S_RX, S_PROCESS, S_TX} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [NUM_IN];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      rd_addr;
  logic [ADDR_W-1:0]     rd_idx;

  // BRAM read stage: data appears one cycle after rd_addr is presented
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic                  rd_vld_p1;
  logic                  rd_last_p1;

  // Skid slot behind the output register, absorbs the read in flight on a stall
  logic [DATA_WIDTH-1:0] sk_data;
  logic                  sk_vld;
  logic                  sk_last;

  logic       wr_en;
  logic       pop;
  logic       issue;
  logic       done_any;
  logic [1:0] occ;

  assign wr_en = (state == S_RX) && s_axis_tvalid && s_axis_tready;
  assign pop   = m_axis_tvalid && m_axis_tready;

  // Words held or in flight once this cycle's pop is taken; a new read is
  // issued only if it is guaranteed a slot (output reg + skid = 2 entries).
  assign occ   = {1'b0, m_axis_tvalid} + {1'b0, sk_vld} + {1'b0, rd_vld_p1} - {1'b0, pop};
  assign issue = (state == S_TX) && (rd_addr < count) && (occ <= 2'd1);

  // Keep the read index in range once rd_addr has run past the last word
  assign rd_idx = (rd_addr < NUM_IN_C) ? rd_addr[ADDR_W-1:0] : '0;

`ifdef AXIS_DMA_AUTO_DONE_EN
  logic auto_done;

  // Self-generated completion one cycle after proc_start for loopback use
  always_ff @(posedge clk) begin
    if (areset) auto_done <= 1'b0;
    else        auto_done <= proc_start;
  end

  assign done_any = proc_done | auto_done;
`else
  assign done_any = proc_done;
`endif

  // Frame buffer: write port fed by the input stream, synchronous read port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s_axis_tdata;
    rd_data_p1 <= mem[rd_idx];
  end

  // Control FSM with registered handshake outputs and the output queue
  always_ff @(posedge clk) begin
    if (areset) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      count         <= '0;
      rd_addr       <= '0;
      rd_vld_p1     <= 1'b0;
      rd_last_p1    <= 1'b0;
      sk_vld        <= 1'b0;
      sk_last       <= 1'b0;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      proc_start    <= 1'b0;
    end else begin
      proc_start <= 1'b0;
      case (state)
        S_IDLE: begin
          wr_ptr        <= '0;
          rd_addr       <= '0;
          rd_vld_p1     <= 1'b0;
          sk_vld        <= 1'b0;
          m_axis_tvalid <= 1'b0;
          m_axis_tlast  <= 1'b0;
          if (start_process) begin
            state         <= S_RX;
            s_axis_tready <= 1'b1;
          end
        end

        S_RX: begin
          if (wr_en) begin
            if ((wr_ptr == LAST_IDX) || s_axis_tlast) begin
              count         <= CNT_W'(wr_ptr) + CNT_W'(1);
              s_axis_tready <= 1'b0;
              proc_start    <= 1'b1;
              state         <= S_PROCESS;
            end else begin
              wr_ptr <= wr_ptr + ADDR_W'(1);
            end
          end
        end

        S_PROCESS: begin
          // rd_addr sits at 0 here, so word 0 is already being read; count it
          // as the first issued read to save a cycle of TX latency.
          if (done_any) begin
            state      <= S_TX;
            rd_vld_p1  <= 1'b1;
            rd_last_p1 <= (count == CNT_W'(1));
            rd_addr    <= CNT_W'(1);
          end
        end

        S_TX: begin
          rd_vld_p1 <= issue;
          if (issue) begin
            rd_addr    <= rd_addr + CNT_W'(1);
            rd_last_p1 <= (rd_addr == count - CNT_W'(1));
          end

          if (m_axis_tvalid && !pop) begin
            // Stalled: hold the output word, park any arriving read in the skid
            if (rd_vld_p1 && !sk_vld) begin
              sk_data <= rd_data_p1;
              sk_last <= rd_last_p1;
              sk_vld  <= 1'b1;
            end
          end else if (sk_vld) begin
            m_axis_tdata  <= sk_data;
            m_axis_tlast  <= sk_last;
            m_axis_tvalid <= 1'b1;
            sk_data       <= rd_data_p1;
            sk_last       <= rd_last_p1;
            sk_vld        <= rd_vld_p1;
          end else if (rd_vld_p1) begin
            m_axis_tdata  <= rd_data_p1;
            m_axis_tlast  <= rd_last_p1;
            m_axis_tvalid <= 1'b1;
          end else begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
          end

          if (pop && m_axis_tlast) begin
            state         <= S_IDLE;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            sk_vld        <= 1'b0;
            rd_vld_p1     <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_dma_bram_fsm.sv
// Bench for axis_dma_bram_fsm: random and directed frames, checked against a
// frame-level model (accepted words queued, replayed in order with TLAST on
// the final word of each frame).
module tb_axis_dma_bram_fsm;

  localparam int DW  = 32;
  localparam int LEN = 16;
  localparam int NUM = 3 * LEN;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic          start_process = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          proc_start;
  logic          proc_done = 1'b0;

  axis_dma_bram_fsm #(.DATA_WIDTH(DW), .length(LEN)) dut (
    .clk           (clk),
    .areset        (areset),
    .start_process (start_process),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .proc_start    (proc_start),
    .proc_done     (proc_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } item_t;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  item_t         expq[$];
  logic [DW-1:0] rxq[$];
  int            len_q[$];
  logic [DW-1:0] out_log[$];
  logic [DW-1:0] frame_data[NUM];

  int cyc = 0, out_frames = 0, ps_count = 0;
  int done_delay = 5, tr_mode = 0;
  int done_cyc = 0, first_cyc = 0, mon_n = 0;
  bit ps_exp1 = 0, ps_exp2 = 0, rdy_drop_chk = 0, idle_chk = 0, hold_chk = 0;
  bit in_proc = 0, lat_pend = 0, tx_started = 0;
  logic [DW-1:0] hold_d = '0;
  logic          hold_l = 1'b0;
  item_t         mon_it, mon_tmp;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Model and compare process, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (areset) begin
      rxq.delete(); expq.delete(); len_q.delete();
      ps_exp1 = 0; ps_exp2 = 0; rdy_drop_chk = 0; idle_chk = 0; hold_chk = 0;
      in_proc = 0; lat_pend = 0; tx_started = 0;
    end else begin
      if (proc_start) ps_count++;
      if (ps_exp1) check("proc_start_pulse", proc_start, 1);
      if (ps_exp2) check("proc_start_single", proc_start, 0);
      ps_exp2 = ps_exp1;
      ps_exp1 = 0;
      if (rdy_drop_chk) check("s_tready_drop", s_axis_tready, 0);
      rdy_drop_chk = 0;
      if (in_proc && proc_done) begin
        done_cyc = cyc; lat_pend = 1; in_proc = 0;
      end
      if (idle_chk) check("tx_idle_after_last", {m_axis_tvalid, m_axis_tlast}, 0);
      idle_chk = 0;
      if (hold_chk)
        check("tx_hold_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, hold_l, hold_d});
      hold_chk = m_axis_tvalid && !m_axis_tready;
      hold_d   = m_axis_tdata;
      hold_l   = m_axis_tlast;
      if (m_axis_tvalid && !tx_started) begin
        tx_started = 1;
        first_cyc  = cyc;
        if (lat_pend) check("tx_first_latency_le2", (cyc - done_cyc) <= 2, 1);
        lat_pend = 0;
        in_proc  = 0;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        out_log.push_back(m_axis_tdata);
        check("tx_word_expected", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          mon_it = expq.pop_front();
          check("tx_data", m_axis_tdata, mon_it.d);
          check("tx_last", m_axis_tlast, mon_it.l);
          if (mon_it.l) begin
            idle_chk   = 1;
            tx_started = 0;
            out_frames++;
            mon_n = (len_q.size() != 0) ? len_q.pop_front() : 0;
            if (tr_mode == 0) check("tx_throughput_cycles", cyc - first_cyc + 1, mon_n);
          end
        end
      end
      if (s_axis_tvalid && s_axis_tready) begin
        rxq.push_back(s_axis_tdata);
        if (rxq.size() == NUM || s_axis_tlast) begin
          for (int i = 0; i < rxq.size(); i++) begin
            mon_tmp.d = rxq[i];
            mon_tmp.l = (i == rxq.size() - 1);
            expq.push_back(mon_tmp);
          end
          len_q.push_back(rxq.size());
          rxq.delete();
          ps_exp1 = 1; rdy_drop_chk = 1; in_proc = 1;
        end
      end
    end
  end

  // Downstream ready pattern: 0 always ready, 1 toggling, 2 random
  initial forever begin
    @(posedge clk); #1;
    case (tr_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Processing-core stand-in: answers proc_start after done_delay cycles
  initial forever begin
    @(posedge clk); #1;
    if (!areset && proc_start) begin
      repeat (done_delay) begin @(posedge clk); #1; end
      proc_done = 1'b1;
      @(posedge clk); #1;
      proc_done = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic pulse_start();
    start_process = 1'b1;
    @(posedge clk); #1;
    start_process = 1'b0;
  endtask

  task automatic check_ready_soon();
    bit found = 0;
    for (int k = 0; k < 3; k++) begin
      if (s_axis_tready) begin found = 1; break; end
      @(posedge clk); #1;
    end
    check("s_tready_after_start", found, 1);
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic l);
    bit rdy = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    for (int c = 0; c < 300; c++) begin
      rdy = s_axis_tready;
      @(posedge clk); #1;
      if (rdy) break;
    end
    check("rx_word_accepted", rdy, 1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int n, input int tlast_at, input int gap);
    int g;
    for (int i = 0; i < n; i++) begin
      send_word(frame_data[i], (i == tlast_at));
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin @(posedge clk); #1; end
    end
  endtask

  task automatic offer_extra();
    bit any = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hDEADBEEF;
    repeat (3) begin
      any |= s_axis_tready;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    check("no_accept_after_frame", any, 0);
  endtask

  task automatic wait_out(input int target);
    for (int c = 0; c < 4000; c++) begin
      if (out_frames >= target) break;
      @(posedge clk); #1;
    end
    check("frame_output_done", out_frames, target);
  endtask

  task automatic run_frame(input int n, input int tlast_at, input int gap,
                           input int dly, input int trm, input bit extra_start);
    int ps0, target;
    done_delay = dly;
    tr_mode    = trm;
    out_log.delete();
    ps0    = ps_count;
    target = out_frames + 1;
    pulse_start();
    check_ready_soon();
    send_frame(n, tlast_at, gap);
    offer_extra();
    if (extra_start) pulse_start();
    wait_out(target);
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_rx", s_axis_tready, 0);
    check("proc_start_count", ps_count - ps0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_tready"}, s_axis_tready, 0);
    check({tag, "_m_tvalid"}, m_axis_tvalid, 0);
    check({tag, "_m_tlast"}, m_axis_tlast, 0);
    check({tag, "_proc_start"}, proc_start, 0);
    check({tag, "_m_tdata"}, m_axis_tdata, 0);
  endtask

  initial begin
    int n, tl;
    areset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    areset = 1'b0;
    @(posedge clk); #1;

    // Words 50,60,...,520 with one idle cycle between words
    for (int i = 0; i < NUM; i++) frame_data[i] = DW'(50 + 10 * i);
    run_frame(NUM, NUM - 1, 1, 5, 0, 0);
    check("t3_len", out_log.size(), 48);
    check("t3_first", out_log[0], 50);
    check("t3_last", out_log[47], 520);

    // Same frame, ready toggling, stray start_process while busy
    run_frame(NUM, NUM - 1, 1, 5, 1, 1);
    check("t4_len", out_log.size(), 48);
    check("t4_second", out_log[1], 60);
    check("t4_last", out_log[47], 520);

    // Early tlast on the 10th word
    for (int i = 0; i < 10; i++) frame_data[i] = DW'(i + 1);
    run_frame(10, 9, 0, 3, 0, 0);
    check("t5_len", out_log.size(), 10);
    check("t5_last", out_log[9], 10);

    // Full frame ended by the count limit alone, done in the proc_start cycle
    for (int i = 0; i < NUM; i++) frame_data[i] = $urandom;
    run_frame(NUM, -1, -1, 0, 2, 0);
    check("t5b_len", out_log.size(), 48);

    // Reset after 20 accepted words aborts the frame
    for (int i = 0; i < NUM; i++) frame_data[i] = $urandom;
    pulse_start();
    check_ready_soon();
    for (int i = 0; i < 20; i++) send_word(frame_data[i], 1'b0);
    areset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrx_reset");
    @(posedge clk); #1;
    areset = 1'b0;
    @(posedge clk); #1;
    check("midrx_no_output", out_frames, 4);
    for (int i = 0; i < NUM; i++) frame_data[i] = $urandom;
    run_frame(NUM, NUM - 1, 0, 2, 2, 0);
    check("t6_len", out_log.size(), 48);
    check("t6_first", out_log[0], frame_data[0]);

    // Random frame lengths, gaps, done delays and ready patterns
    for (int f = 0; f < 5; f++) begin
      n  = (f == 0) ? 1 : int'($urandom_range(1, NUM));
      tl = (n == NUM && $urandom_range(0, 1) == 1) ? -1 : n - 1;
      for (int i = 0; i < NUM; i++) frame_data[i] = $urandom;
      run_frame(n, tl, -1, int'($urandom_range(0, 6)), int'($urandom_range(0, 2)), 0);
      check("rand_len", out_log.size(), n);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
